mmio_ctrl: RTL
==============

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter DBITS, 32, data and address width.
REQ-002 Parameter DEBOUNCE_CYCLES, 100000, stable-input cycles required before a KEY/SW change is accepted; minimum 2.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  DBITS  byte address from the ALU result.
REQ-006 wrData  in  DBITS  store data from the second register-file read port.
REQ-007 wrEn  in  1  store strobe, one cycle per store.
REQ-008 rdEn  in  1  load strobe, one cycle per load.
REQ-009 KEY  in  4  raw pushbuttons, active-low, asynchronous.
REQ-010 SW  in  10  raw switches, active-high, asynchronous.
REQ-011 rdData  out  DBITS  load result, feeding the register-file I/O write-back select.
REQ-012 isIo  out  1  high when addr hits a mapped register.
REQ-013 HEX0..HEX3  out  7 each  seven-segment drives, active-low, bit order gfedcba.
REQ-014 LEDR  out  10  red LEDs, active-high.

Function
REQ-015 Register map, full 32-bit compare, word access only: HEX F0000000 (RW, bits 15:0), LEDR F0000004 (RW, bits 9:0), KEYDATA F0000010 (RO), SWDATA F0000014 (RO), KEYCTRL F0000110 (RW), SWCTRL F0000114 (RW).
REQ-016 isIo and rdData are combinational from addr; rdData = zero-extended register value; unmapped addr -> isIo=0, rdData=0.
REQ-017 Writes take effect on the edge where wrEn=1; writes to RO or unmapped addresses are ignored; unused upper bits read as 0.
REQ-018 HEXn displays nibble HEX[4n+3:4n]: 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E (hex).
REQ-019 LEDR output is the LEDR register, directly.
REQ-020 KEY and SW each pass through a 2-flop synchronizer; KEY is inverted after sync (1 = pressed).
REQ-021 Each group (KEY, SW) has one stability counter: cleared when the synced vector differs from its previous-cycle value or equals the debounced value; otherwise increments.
REQ-022 Debounced value loads the synced vector on the edge where the counter equals DEBOUNCE_CYCLES-1; that edge is a change event for that group.
REQ-023 Latency: a raw input held stable updates the debounced value on exactly the (DEBOUNCE_CYCLES+2)th edge after the change; any glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
REQ-024 KEYDATA/SWDATA read the debounced value; CTRL reads bit0 = ready, bit2 = overrun.
REQ-025 Change event sets ready; change event while ready=1 and no clearing read in that cycle also sets overrun.
REQ-026 Edge with rdEn=1 on the DATA address clears ready; simultaneous change event wins (ready stays 1, overrun unchanged).
REQ-027 Write to CTRL with bit2=0 clears overrun; writes to bit0 ignored; simultaneous overrun-setting event wins over the clear.
REQ-028 wrEn and rdEn asserted together are serviced independently.

Reset
REQ-029 On an edge with reset=1: HEX=0 (all four displays show 0, output 40), LEDR=0, synced and debounced KEY = not pressed (0), synced and debounced SW = 0, counters=0, ready=0, overrun=0.
REQ-030 Reset overrides any concurrent write, read side effect, or change event; a debounce in progress is discarded.
REQ-031 SW nonzero at reset release produces a normal change event after DEBOUNCE_CYCLES+2 edges.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Store 0x0000BEEF to F0000000 -> HEX3..0 = 03,06,06,0E; load returns 0x0000BEEF; LEDR unchanged.
REQ-033 KEY[1] driven low and held -> KEYDATA=0x2 and KEYCTRL=0x1 from the 6th edge; KEY[1] low for 3 cycles only -> KEYDATA stays 0.
REQ-034 Two accepted SW changes with no intervening SWDATA read -> SWCTRL=0x5; store 0 to F0000114 -> 0x1; load F0000014 -> 0x0.
REQ-035 Change event on the same edge as a KEYDATA read -> ready=1, overrun=0.
REQ-036 Load 0xF0000018 -> isIo=0, rdData=0; store there -> no register changes.
REQ-037 Reset asserted mid-debounce and with LEDR=0x3FF -> LEDR=0, counters 0, CTRL=0 next cycle.

Source files
------------

// File: rtl/mmio_if.sv
// CPU-side load/store bus for the memory-mapped I/O block.
interface mmio_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wrData;
    logic             wrEn;
    logic             rdEn;
    logic [DBITS-1:0] rdData;
    logic             isIo;

    modport master (output addr, output wrData, output wrEn, output rdEn,
                    input  rdData, input isIo);
    modport slave  (input  addr, input wrData, input wrEn, input rdEn,
                    output rdData, output isIo);
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O: HEX/LEDR output registers and debounced KEY/SW inputs
// with per-group ready/overrun status.
module mmio_ctrl #(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    mmio_if.slave       bus,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [9:0]  LEDR
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [DBITS-1:0] A_HEX     = DBITS'(32'hF000_0000);
    localparam logic [DBITS-1:0] A_LEDR    = DBITS'(32'hF000_0004);
    localparam logic [DBITS-1:0] A_KEYDATA = DBITS'(32'hF000_0010);
    localparam logic [DBITS-1:0] A_SWDATA  = DBITS'(32'hF000_0014);
    localparam logic [DBITS-1:0] A_KEYCTRL = DBITS'(32'hF000_0110);
    localparam logic [DBITS-1:0] A_SWCTRL  = DBITS'(32'hF000_0114);

    logic [15:0]      r_hex;
    logic [9:0]       r_ledr;
    logic [3:0]       r_key_s1, r_key_s2, r_key_db;
    logic [9:0]       r_sw_s1, r_sw_s2, r_sw_db;
    logic [CNT_W-1:0] r_key_cnt, r_sw_cnt;
    logic             r_key_rdy, r_key_ovr, r_sw_rdy, r_sw_ovr;

    logic [3:0]       w_key_sync, w_key_next;
    logic [CNT_W-1:0] w_key_cnt_n, w_sw_cnt_n;
    logic             w_key_evt, w_sw_evt;
    logic             w_key_rd_clr, w_sw_rd_clr, w_key_wr_clr, w_sw_wr_clr;
    logic             w_key_rdy_n, w_key_ovr_n, w_sw_rdy_n, w_sw_ovr_n;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // KEY is active-low on the board; invert so 1 means pressed.
    assign w_key_sync = ~r_key_s2;
    assign w_key_next = ~r_key_s1;

    // Stability counters: the synced vector is about to change when s1 != s2.
    always_comb begin
        w_key_cnt_n = r_key_cnt + CNT_W'(1);
        w_sw_cnt_n  = r_sw_cnt + CNT_W'(1);
        if ((w_key_next != w_key_sync) || (w_key_sync == r_key_db))
            w_key_cnt_n = '0;
        if ((r_sw_s1 != r_sw_s2) || (r_sw_s2 == r_sw_db))
            w_sw_cnt_n = '0;
        w_key_evt = (r_key_cnt == CNT_LAST) && (w_key_sync != r_key_db);
        w_sw_evt  = (r_sw_cnt == CNT_LAST) && (r_sw_s2 != r_sw_db);
    end

    // Ready/overrun: a change event takes priority over both clear sources.
    always_comb begin
        w_key_rd_clr = bus.rdEn && (bus.addr == A_KEYDATA);
        w_sw_rd_clr  = bus.rdEn && (bus.addr == A_SWDATA);
        w_key_wr_clr = bus.wrEn && (bus.addr == A_KEYCTRL) && !bus.wrData[2];
        w_sw_wr_clr  = bus.wrEn && (bus.addr == A_SWCTRL) && !bus.wrData[2];

        w_key_rdy_n = w_key_evt ? 1'b1 : (w_key_rd_clr ? 1'b0 : r_key_rdy);
        w_sw_rdy_n  = w_sw_evt  ? 1'b1 : (w_sw_rd_clr  ? 1'b0 : r_sw_rdy);
        w_key_ovr_n = (w_key_evt && r_key_rdy && !w_key_rd_clr) ? 1'b1 :
                      (w_key_wr_clr ? 1'b0 : r_key_ovr);
        w_sw_ovr_n  = (w_sw_evt && r_sw_rdy && !w_sw_rd_clr) ? 1'b1 :
                      (w_sw_wr_clr ? 1'b0 : r_sw_ovr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex     <= '0;
            r_ledr    <= '0;
            r_key_s1  <= '1;
            r_key_s2  <= '1;
            r_key_db  <= '0;
            r_key_cnt <= '0;
            r_key_rdy <= 1'b0;
            r_key_ovr <= 1'b0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_db   <= '0;
            r_sw_cnt  <= '0;
            r_sw_rdy  <= 1'b0;
            r_sw_ovr  <= 1'b0;
        end else begin
            r_key_s1  <= KEY;
            r_key_s2  <= r_key_s1;
            r_key_cnt <= w_key_cnt_n;
            r_key_rdy <= w_key_rdy_n;
            r_key_ovr <= w_key_ovr_n;
            if (w_key_evt) r_key_db <= w_key_sync;

            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
            r_sw_cnt <= w_sw_cnt_n;
            r_sw_rdy <= w_sw_rdy_n;
            r_sw_ovr <= w_sw_ovr_n;
            if (w_sw_evt) r_sw_db <= r_sw_s2;

            if (bus.wrEn && (bus.addr == A_HEX))  r_hex  <= bus.wrData[15:0];
            if (bus.wrEn && (bus.addr == A_LEDR)) r_ledr <= bus.wrData[9:0];
        end
    end

    // Load path is purely combinational from the address.
    always_comb begin
        bus.rdData = '0;
        bus.isIo   = 1'b1;
        case (bus.addr)
            A_HEX:     bus.rdData = DBITS'(r_hex);
            A_LEDR:    bus.rdData = DBITS'(r_ledr);
            A_KEYDATA: bus.rdData = DBITS'(r_key_db);
            A_SWDATA:  bus.rdData = DBITS'(r_sw_db);
            A_KEYCTRL: bus.rdData = DBITS'({r_key_ovr, 1'b0, r_key_rdy});
            A_SWCTRL:  bus.rdData = DBITS'({r_sw_ovr, 1'b0, r_sw_rdy});
            default:   bus.isIo   = 1'b0;
        endcase
    end

    assign HEX0 = seg7(r_hex[3:0]);
    assign HEX1 = seg7(r_hex[7:4]);
    assign HEX2 = seg7(r_hex[11:8]);
    assign HEX3 = seg7(r_hex[15:12]);
    assign LEDR = r_ledr;
endmodule
